instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_if.sv | 39 +++
 rtl/instr_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// Shared widths/payload type and the instruction + control-FSM bus used by instr_sequencer.

package instr_sequencer_pkg;
  localparam int unsigned FUNC_W  = 4;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned STATE_W = 5;
  localparam int unsigned INSTR_W = FUNC_W + 2 * REG_W;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STEP_W  = 4;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rx;
    logic [REG_W-1:0]  ry;
  } instr_t;
endpackage

interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [STATE_W-1:0] next_state;
  logic [FUNC_W-1:0]  func;
  logic [REG_W-1:0]   input1;
  logic [REG_W-1:0]   input2;
  logic [STATE_W-1:0] current_state;

  modport slave (
    input  instr_valid, instr, next_state,
    output instr_ready, func, input1, input2, current_state
  );

  modport master (
    output instr_valid, instr, next_state,
    input  instr_ready, func, input1, input2, current_state
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: 2-entry instruction FIFO feeding an external control FSM.
// Optional step watchdog enabled by defining SEQ_WATCHDOG_EN.

module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  instr_sequencer_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  state_e             state_q, state_d;
  instr_t             fifo_mem [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         fifo_count;
  logic               push_c, pop_c, legal_c, complete_c, expire_c;
  instr_t             head_c;

  logic [FUNC_W-1:0]  func_q, func_d;
  logic [REG_W-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic [STATE_W-1:0] cs_q, cs_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               done_d, illegal_d, timeout_d;

  assign bus.instr_ready  = reset_n && (fifo_count < 2'd2);
  assign bus.func          = func_q;
  assign bus.input1        = in1_q;
  assign bus.input2        = in2_q;
  assign bus.current_state = cs_q;
  assign busy              = (state_q == S_EXEC);
  assign retired_count     = retired_q;

  assign push_c     = bus.instr_valid && bus.instr_ready;
  assign pop_c      = (state_q == S_IDLE) && (fifo_count != 2'd0);
  assign head_c     = fifo_mem[rd_ptr];
  assign legal_c    = (head_c.func >= 4'd1) && (head_c.func <= 4'd5);
  assign complete_c = (state_q == S_EXEC) && (bus.next_state == '0) && (step_q != '0);

`ifdef SEQ_WATCHDOG_EN
  assign expire_c = (state_q == S_EXEC) && !complete_c && (step_q == STEP_W'(15));
`else
  assign expire_c = 1'b0;
`endif

  // FIFO storage carries no reset; occupancy and pointers do
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= instr_t'(bus.instr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push_c) wr_ptr <= ~wr_ptr;
      if (pop_c)  rd_ptr <= ~rd_ptr;
      unique case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (pop_c && legal_c)       state_d = S_EXEC;
      S_EXEC: if (complete_c || expire_c) state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs; IDLE presents all zeros
  always_comb begin
    func_d    = '0;
    in1_d     = '0;
    in2_d     = '0;
    cs_d      = '0;
    step_d    = step_q;
    retired_d = retired_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        step_d = '0;
        if (pop_c) begin
          if (legal_c) begin
            func_d = head_c.func;
            in1_d  = head_c.rx;
            in2_d  = head_c.ry;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (complete_c) begin
          done_d    = 1'b1;
          retired_d = retired_q + CNT_W'(1);
        end else if (expire_c) begin
          timeout_d = 1'b1;
        end else begin
          func_d = func_q;
          in1_d  = in1_q;
          in2_d  = in2_q;
          cs_d   = bus.next_state;
          step_d = (step_q == STEP_W'(15)) ? step_q : step_q + STEP_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      func_q    <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      cs_q      <= '0;
      step_q    <= '0;
      retired_q <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      func_q    <= func_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      cs_q      <= cs_d;
      step_q    <= step_d;
      retired_q <= retired_d;
      done      <= done_d;
      illegal   <= illegal_d;
      timeout   <= timeout_d;
    end
  end

endmodule
